rc4_phase_controller: RTL and testbench
=======================================

# rc4_phase_controller

Top-level sequencer for one RC4 key-trial datapath. Runs the S-memory init engine, the shuffle engine, and the decrypt/check engine in strict order for a candidate 24-bit key. Holds each engine in reset outside its phase and multiplexes the single-port S memory to whichever engine owns the current phase. On a failed trial it advances to the next key, with optional key search compiled in.

## Interface
- KEY_WIDTH, 24, width of secret key and key counter.
- ADDR_WIDTH, 8, S-memory address width.
- CLOCK_50  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high; forces IDLE.
- start  in  1  one-cycle pulse; begins a run from `key_in`.
- key_in  in  KEY_WIDTH  first (or only) key to try; captured on accepted `start`.
- key_limit  in  KEY_WIDTH  last key to try; captured on accepted `start`; ignored without the macro.
- init_done, shuffle_done, decrypt_done  in  1  level done flags from the engines.
- decrypt_pass  in  1  valid only with `decrypt_done`; 1 = plaintext accepted.
- init_reset, shuffle_reset, decrypt_reset  out  1  active-high engine holds.
- init_addr/shuf_addr/dec_addr  in  ADDR_WIDTH; init_wdata/shuf_wdata/dec_wdata  in  8; init_wren/shuf_wren/dec_wren  in  1  per-engine S-memory requests.
- s_addr  out  ADDR_WIDTH; s_wdata  out  8; s_wren  out  1  S-memory port.
- current_key  out  KEY_WIDTH  key under trial; drives the engines' `secret_key`.
- busy  out  1  high in any RUN or NEXT_KEY state.
- key_found, search_failed  out  1  sticky result flags.

## Operation
- States: IDLE, INIT_RUN, SHUFFLE_RUN, DECRYPT_RUN, NEXT_KEY, FOUND, FAILED.
- IDLE, FOUND, FAILED: `start`=1 captures `key_in` into `current_key` and `key_limit` into an internal register, clears both flags, and moves to INIT_RUN. `start` in any other state is ignored.
- INIT_RUN: `init_done`=1 moves to SHUFFLE_RUN.
- SHUFFLE_RUN: `shuffle_done`=1 moves to DECRYPT_RUN.
- DECRYPT_RUN: `decrypt_done`=1 with `decrypt_pass`=1 moves to FOUND. With `decrypt_pass`=0 it moves to NEXT_KEY.
- NEXT_KEY (macro on): if `current_key` >= limit, go to FAILED. Otherwise `current_key`+1 and go to INIT_RUN. No wrap past all-ones.
- NEXT_KEY (macro off): always go to FAILED.
- Engine resets are decoded from the state register:
  - `init_reset`=0 only in INIT_RUN.
  - `shuffle_reset`=0 only in SHUFFLE_RUN.
  - `decrypt_reset`=0 only in DECRYPT_RUN.
- Each engine is therefore re-reset for at least one cycle between trials.
- A done flag is honoured only in its own phase. Done or pass from an inactive engine is ignored.
- Memory mux is combinational on the state register:
  - INIT_RUN selects the init engine.
  - SHUFFLE_RUN selects the shuffle engine.
  - DECRYPT_RUN selects the decrypt engine.
  - All other states drive `s_addr`=0, `s_wdata`=0, `s_wren`=0.
- FOUND sets `key_found`=1. FAILED sets `search_failed`=1. Both hold until reset or the next accepted `start`. `current_key` holds the last key tried.

## Timing
- Reset values: state IDLE, all `*_reset`=1, `current_key`=0, `busy`=0, `key_found`=0, `search_failed`=0, `s_wren`=0, `s_addr`=0, `s_wdata`=0.
- Reset is taken on any cycle, including mid-phase, and overrides `start`.
- `start` sampled at edge N: state is INIT_RUN and `init_reset`=0 from edge N+1.
- Done sampled at edge M: next state is active from M+1. The old engine's reset rises and the new engine's reset falls on the same edge. No dead cycle between phases.
- Failed trial: DECRYPT_RUN → NEXT_KEY (1 cycle) → INIT_RUN. Trial-to-trial overhead is 1 cycle plus engine latencies.
- Mux adds zero latency. Engine read data returns straight from memory, unregistered by this block.
- `decrypt_done` and `decrypt_pass` must be valid in the same cycle.

## Configuration
- `RC4_KEY_SEARCH_EN` defined: NEXT_KEY increments and retries until `current_key` >= captured limit. `key_limit` < `key_in` tries exactly one key.
- Undefined: exactly one trial per `start`. `key_limit` is unused and no comparator or incrementer is built. A failed trial goes to FAILED.

## Test plan
- Reset mid-SHUFFLE_RUN, then release → all engine resets 1, `current_key`=0, `s_wren`=0, `busy`=0, state IDLE.
- `start` with `key_in`=24'h000249 and stub engines (done after 256/1000/40 cycles, pass=1) → phases in order, no overlap of active resets, `key_found`=1, `current_key`=24'h000249.
- Macro on: `key_in`=24'h000010, `key_limit`=24'h000013, pass only at key 24'h000012 → three trials, `key_found`=1, `current_key`=24'h000012.
- Macro on: `key_in`=24'hFFFFFE, `key_limit`=24'hFFFFFF, never pass → keys FFFFFE and FFFFFF tried, `search_failed`=1, no wrap to 0.
- Spurious `shuffle_done`=1 and `decrypt_done`=1 during INIT_RUN, plus `start` pulse while busy → ignored; phase order and captured key unchanged.
- Mux check: drive distinct addr/wdata/wren on all three engine ports → `s_*` matches only the active phase. IDLE, NEXT_KEY, FOUND and FAILED drive zeros.

Source files
------------

// File: rtl/rc4_phase_controller.sv
// Sequencer for one RC4 key-trial datapath: init -> shuffle -> decrypt, with S-memory muxing.
// Optional multi-key search is compiled in with `define RC4_KEY_SEARCH_EN.
module rc4_phase_controller #(
    parameter int KEY_WIDTH  = 24,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic                  start,
    input  logic [KEY_WIDTH-1:0]  key_in,
    input  logic [KEY_WIDTH-1:0]  key_limit,
    input  logic                  init_done,
    input  logic                  shuffle_done,
    input  logic                  decrypt_done,
    input  logic                  decrypt_pass,
    output logic                  init_reset,
    output logic                  shuffle_reset,
    output logic                  decrypt_reset,
    input  logic [ADDR_WIDTH-1:0] init_addr,
    input  logic [7:0]            init_wdata,
    input  logic                  init_wren,
    input  logic [ADDR_WIDTH-1:0] shuf_addr,
    input  logic [7:0]            shuf_wdata,
    input  logic                  shuf_wren,
    input  logic [ADDR_WIDTH-1:0] dec_addr,
    input  logic [7:0]            dec_wdata,
    input  logic                  dec_wren,
    output logic [ADDR_WIDTH-1:0] s_addr,
    output logic [7:0]            s_wdata,
    output logic                  s_wren,
    output logic [KEY_WIDTH-1:0]  current_key,
    output logic                  busy,
    output logic                  key_found,
    output logic                  search_failed
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT_RUN,
        S_SHUFFLE_RUN,
        S_DECRYPT_RUN,
        S_NEXT_KEY,
        S_FOUND,
        S_FAILED
    } state_t;

    state_t state_q, state_d;
    logic   start_accept;

    assign start_accept = start &&
        (state_q == S_IDLE || state_q == S_FOUND || state_q == S_FAILED);

`ifdef RC4_KEY_SEARCH_EN
    logic [KEY_WIDTH-1:0] key_limit_q;
    logic                 key_at_limit;

    // >= also covers all-ones, so the key never wraps to zero
    assign key_at_limit = (current_key >= key_limit_q);
`else
    logic unused_key_limit;
    assign unused_key_limit = ^key_limit;
`endif

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q     <= S_IDLE;
            current_key <= '0;
`ifdef RC4_KEY_SEARCH_EN
            key_limit_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (start_accept) begin
                current_key <= key_in;
`ifdef RC4_KEY_SEARCH_EN
                key_limit_q <= key_limit;
`endif
            end
`ifdef RC4_KEY_SEARCH_EN
            if (state_q == S_NEXT_KEY && !key_at_limit)
                current_key <= current_key + KEY_WIDTH'(1);
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_FOUND, S_FAILED:
                if (start) state_d = S_INIT_RUN;
            S_INIT_RUN:
                if (init_done) state_d = S_SHUFFLE_RUN;
            S_SHUFFLE_RUN:
                if (shuffle_done) state_d = S_DECRYPT_RUN;
            S_DECRYPT_RUN:
                if (decrypt_done) state_d = decrypt_pass ? S_FOUND : S_NEXT_KEY;
            S_NEXT_KEY: begin
`ifdef RC4_KEY_SEARCH_EN
                state_d = key_at_limit ? S_FAILED : S_INIT_RUN;
`else
                state_d = S_FAILED;
`endif
            end
            default:
                state_d = S_IDLE;
        endcase
    end

    // Result flags are the terminal states themselves: they hold until reset or the next start
    always_comb begin
        init_reset    = (state_q != S_INIT_RUN);
        shuffle_reset = (state_q != S_SHUFFLE_RUN);
        decrypt_reset = (state_q != S_DECRYPT_RUN);
        busy          = (state_q == S_INIT_RUN) || (state_q == S_SHUFFLE_RUN) ||
                        (state_q == S_DECRYPT_RUN) || (state_q == S_NEXT_KEY);
        key_found     = (state_q == S_FOUND);
        search_failed = (state_q == S_FAILED);
    end

    always_comb begin
        s_addr  = '0;
        s_wdata = '0;
        s_wren  = 1'b0;
        unique case (state_q)
            S_INIT_RUN: begin
                s_addr  = init_addr;
                s_wdata = init_wdata;
                s_wren  = init_wren;
            end
            S_SHUFFLE_RUN: begin
                s_addr  = shuf_addr;
                s_wdata = shuf_wdata;
                s_wren  = shuf_wren;
            end
            S_DECRYPT_RUN: begin
                s_addr  = dec_addr;
                s_wdata = dec_wdata;
                s_wren  = dec_wren;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rc4_phase_controller.sv
// Bench for rc4_phase_controller: stub engines, per-cycle phase model, directed key trials.
module tb_rc4_phase_controller;

    logic        CLOCK_50 = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [23:0] key_in = '0;
    logic [23:0] key_limit = '0;
    logic        init_done, shuffle_done, decrypt_done, decrypt_pass;
    logic        init_reset, shuffle_reset, decrypt_reset;
    logic [7:0]  init_addr = '0, shuf_addr = '0, dec_addr = '0;
    logic [7:0]  init_wdata = '0, shuf_wdata = '0, dec_wdata = '0;
    logic        init_wren = 1'b0, shuf_wren = 1'b0, dec_wren = 1'b0;
    logic [7:0]  s_addr, s_wdata;
    logic        s_wren;
    logic [23:0] current_key;
    logic        busy, key_found, search_failed;

    rc4_phase_controller #(.KEY_WIDTH(24), .ADDR_WIDTH(8)) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .start(start),
        .key_in(key_in), .key_limit(key_limit),
        .init_done(init_done), .shuffle_done(shuffle_done),
        .decrypt_done(decrypt_done), .decrypt_pass(decrypt_pass),
        .init_reset(init_reset), .shuffle_reset(shuffle_reset), .decrypt_reset(decrypt_reset),
        .init_addr(init_addr), .init_wdata(init_wdata), .init_wren(init_wren),
        .shuf_addr(shuf_addr), .shuf_wdata(shuf_wdata), .shuf_wren(shuf_wren),
        .dec_addr(dec_addr), .dec_wdata(dec_wdata), .dec_wren(dec_wren),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_wren(s_wren),
        .current_key(current_key), .busy(busy),
        .key_found(key_found), .search_failed(search_failed)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int compared = 0;
    int mismatched = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Stub engines: done rises after a programmable number of released cycles
    int init_lat = 10, shuf_lat = 10, dec_lat = 10;
    int icnt = 0, scnt = 0, dcnt = 0;
    logic [23:0] pass_key = '0;
    logic f_shuf_done = 1'b0, f_dec_done = 1'b0, f_pass = 1'b0;

    always @(posedge CLOCK_50) begin
        icnt <= init_reset    ? 0 : icnt + 1;
        scnt <= shuffle_reset ? 0 : scnt + 1;
        dcnt <= decrypt_reset ? 0 : dcnt + 1;
    end

    assign init_done    = !init_reset && (icnt >= init_lat);
    assign shuffle_done = (!shuffle_reset && (scnt >= shuf_lat)) || f_shuf_done;
    assign decrypt_done = (!decrypt_reset && (dcnt >= dec_lat)) || f_dec_done;
    assign decrypt_pass = (decrypt_done && current_key == pass_key) || f_pass;

    // Phase model: 0 idle, 1 init, 2 shuffle, 3 decrypt, 4 next-key, 5 found, 6 failed
    int          m_ph = 0;
    logic [23:0] m_key = '0, m_lim = '0;
    bit          chk_en = 1'b0;

    always @(posedge CLOCK_50) begin
        if (reset) begin
            m_ph = 0;
            m_key = '0;
        end else if (m_ph == 0 || m_ph == 5 || m_ph == 6) begin
            if (start) begin
                m_ph = 1;
                m_key = key_in;
                m_lim = key_limit;
            end
        end else if (m_ph == 1) begin
            if (init_done) m_ph = 2;
        end else if (m_ph == 2) begin
            if (shuffle_done) m_ph = 3;
        end else if (m_ph == 3) begin
            if (decrypt_done) m_ph = decrypt_pass ? 5 : 4;
        end else begin
`ifdef RC4_KEY_SEARCH_EN
            if (m_key >= m_lim) m_ph = 6;
            else begin
                m_key = m_key + 24'd1;
                m_ph = 1;
            end
`else
            m_ph = 6;
`endif
        end
    end

    always @(negedge CLOCK_50) begin
        if (chk_en) begin
            chk("init_reset",    32'(init_reset),    32'(m_ph != 1));
            chk("shuffle_reset", 32'(shuffle_reset), 32'(m_ph != 2));
            chk("decrypt_reset", 32'(decrypt_reset), 32'(m_ph != 3));
            chk("busy",          32'(busy),          32'(m_ph >= 1 && m_ph <= 4));
            chk("key_found",     32'(key_found),     32'(m_ph == 5));
            chk("search_failed", 32'(search_failed), 32'(m_ph == 6));
            chk("current_key",   32'(current_key),   32'(m_key));
            chk("s_addr",  32'(s_addr),  32'(m_ph == 1 ? init_addr  : m_ph == 2 ? shuf_addr  : m_ph == 3 ? dec_addr  : 8'h00));
            chk("s_wdata", 32'(s_wdata), 32'(m_ph == 1 ? init_wdata : m_ph == 2 ? shuf_wdata : m_ph == 3 ? dec_wdata : 8'h00));
            chk("s_wren",  32'(s_wren),  32'(m_ph == 1 ? init_wren  : m_ph == 2 ? shuf_wren  : m_ph == 3 ? dec_wren  : 1'b0));
            chk("one_engine_active", 32'(int'(!init_reset) + int'(!shuffle_reset) + int'(!decrypt_reset) <= 1), 32'd1);
        end
    end

    // Trials counted from falling edges of init_reset
    int   trials = 0;
    logic prev_ir = 1'b1;
    always @(posedge CLOCK_50) begin
        if (prev_ir && !init_reset) trials = trials + 1;
        prev_ir = init_reset;
    end

    // Distinct, changing requests on every engine port
    initial begin
        forever begin
            @(posedge CLOCK_50);
            #1;
            init_addr  = 8'($urandom); init_wdata = 8'($urandom); init_wren = 1'($urandom);
            shuf_addr  = 8'($urandom); shuf_wdata = 8'($urandom); shuf_wren = 1'($urandom);
            dec_addr   = 8'($urandom); dec_wdata  = 8'($urandom); dec_wren  = 1'($urandom);
        end
    end

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic launch(input logic [23:0] k, input logic [23:0] lim, input logic [23:0] pk,
                          input int il, input int sl, input int dl);
        key_in = k; key_limit = lim; pass_key = pk;
        init_lat = il; shuf_lat = sl; dec_lat = dl;
        trials = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_result(input string name);
        int n = 0;
        while (!(key_found || search_failed) && n < 20000) begin
            tick();
            n++;
        end
        compared++;
        if (n >= 20000) begin
            mismatched++;
            $display("FAIL %s_timeout: no result after %0d cycles, expected key_found or search_failed", name, n);
        end
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_init_reset", 32'(init_reset), 32'd1);
        chk("rst_shuffle_reset", 32'(shuffle_reset), 32'd1);
        chk("rst_decrypt_reset", 32'(decrypt_reset), 32'd1);
        chk("rst_key", 32'(current_key), 32'h0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_flags", 32'({key_found, search_failed}), 32'd0);
        chk("rst_mux", 32'({s_addr, s_wdata, s_wren}), 32'd0);
        reset = 1'b0;
        chk_en = 1'b1;
        tick();

        // Single passing trial with realistic engine latencies
        launch(24'h000249, 24'h000000, 24'h000249, 256, 1000, 40);
        chk("t1_init_active", 32'(init_reset), 32'd0);
        wait_result("t1");
        chk("t1_found", 32'(key_found), 32'd1);
        chk("t1_key", 32'(current_key), 32'h000249);
        chk("t1_trials", 32'(trials), 32'd1);
        repeat (3) tick();

        // Reset taken in the middle of the shuffle phase
        launch(24'h000123, 24'h000000, 24'h000123, 20, 50, 10);
        chk("t2_flags_cleared", 32'({key_found, search_failed}), 32'd0);
        begin
            int n = 0;
            while (shuffle_reset && n < 200) begin tick(); n++; end
            chk("t2_reached_shuffle", 32'(shuffle_reset), 32'd0);
        end
        repeat (5) tick();
        reset = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b0;
        chk("t2_init_reset", 32'(init_reset), 32'd1);
        chk("t2_shuffle_reset", 32'(shuffle_reset), 32'd1);
        chk("t2_decrypt_reset", 32'(decrypt_reset), 32'd1);
        chk("t2_key", 32'(current_key), 32'h0);
        chk("t2_wren", 32'(s_wren), 32'd0);
        chk("t2_busy", 32'(busy), 32'd0);
        repeat (5) tick();
        chk("t2_stays_idle", 32'(busy), 32'd0);

        // Spurious done/pass and a start pulse while busy must be ignored
        launch(24'h000055, 24'h000000, 24'h000055, 30, 12, 8);
        repeat (2) tick();
        f_shuf_done = 1'b1; f_dec_done = 1'b1; f_pass = 1'b1;
        key_in = 24'h000099; start = 1'b1;
        tick();
        f_shuf_done = 1'b0; f_dec_done = 1'b0; f_pass = 1'b0; start = 1'b0;
        chk("t3_still_init", 32'({init_reset, shuffle_reset, decrypt_reset}), 32'b011);
        chk("t3_key_kept", 32'(current_key), 32'h000055);
        wait_result("t3");
        chk("t3_found", 32'(key_found), 32'd1);
        chk("t3_key", 32'(current_key), 32'h000055);
        chk("t3_trials", 32'(trials), 32'd1);

        // Failing trial with limit below the start key: exactly one key tried
        launch(24'h000007, 24'h000000, 24'h000042, 5, 6, 7);
        wait_result("t4");
        chk("t4_failed", 32'({key_found, search_failed}), 32'b01);
        chk("t4_key", 32'(current_key), 32'h000007);
        chk("t4_trials", 32'(trials), 32'd1);

`ifdef RC4_KEY_SEARCH_EN
        launch(24'h000010, 24'h000013, 24'h000012, 8, 9, 4);
        wait_result("t5");
        chk("t5_found", 32'(key_found), 32'd1);
        chk("t5_key", 32'(current_key), 32'h000012);
        chk("t5_trials", 32'(trials), 32'd3);

        launch(24'hFFFFFE, 24'hFFFFFF, 24'h000000, 6, 5, 3);
        wait_result("t6");
        chk("t6_failed", 32'({key_found, search_failed}), 32'b01);
        chk("t6_key", 32'(current_key), 32'hFFFFFF);
        chk("t6_trials", 32'(trials), 32'd2);
`else
        launch(24'h000010, 24'h000013, 24'h000012, 8, 9, 4);
        wait_result("t5");
        chk("t5_failed", 32'({key_found, search_failed}), 32'b01);
        chk("t5_key", 32'(current_key), 32'h000010);
        chk("t5_trials", 32'(trials), 32'd1);
`endif
        repeat (4) tick();
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
